// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch stage.
package fetch_pkg;

  // Fetch FSM: IDLE has nothing outstanding, REQ keeps the returning byte,
  // DRAIN throws away a byte whose request predates a redirect.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  localparam logic [15:0] RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {byte, address} entries for the decoder.
// Flush empties the queue in one cycle and takes priority over push/pop.
// A pop on an empty queue is ignored.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_push = i_push && !i_flush;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: issues byte reads over a req/ack handshake and
// queues {byte, address} for the decoder. A branch redirect flushes the queue
// and restarts at the target; a request already on the bus is never withdrawn,
// its data is simply dropped (DRAIN). Queue space is reserved when a request
// is issued, so a returning byte always fits.
// Optional macro FETCH_BYPASS_EN: when the queue is empty, an acked byte is
// presented to the decoder in the ack cycle and skips the queue if consumed.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_addr,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    q_valid,
  output logic [DATA_W-1:0]       q_data,
  output logic [ADDR_W-1:0]       q_addr,
  input  logic                    q_ready,
  output logic [$clog2(DEPTH):0]  q_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  fetch_state_t      r_state,      w_state_nxt;
  logic              r_mem_req,    w_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_maddr_nxt;
  logic [ADDR_W-1:0] r_fetch_addr, w_faddr_nxt;

  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_ack_keep;
  logic              w_fifo_valid;
  logic [ENT_W-1:0]  w_fifo_rdata;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_cnt_after_pop;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [ADDR_W-1:0] w_faddr_inc;

  // An ack in REQ without a redirect delivers a byte we want to keep.
  assign w_ack_keep  = (r_state == REQ) && mem_ack && !redirect;
  assign w_pop       = w_fifo_valid && q_ready && !redirect;
  assign w_faddr_inc = r_fetch_addr + ADDR_W'(1);

`ifdef FETCH_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_ack_keep && !w_fifo_valid;
  assign w_push   = w_ack_keep && !(w_bypass && q_ready);
  assign q_valid  = w_fifo_valid || w_bypass;
  assign q_data   = w_fifo_valid ? w_fifo_rdata[ADDR_W +: DATA_W] : mem_rdata;
  assign q_addr   = w_fifo_valid ? w_fifo_rdata[ADDR_W-1:0] : r_mem_addr;
`else
  assign w_push   = w_ack_keep;
  assign q_valid  = w_fifo_valid;
  assign q_data   = w_fifo_rdata[ADDR_W +: DATA_W];
  assign q_addr   = w_fifo_rdata[ADDR_W-1:0];
`endif

  assign w_cnt_after_pop = w_count - CNT_W'(w_pop);
  assign w_cnt_nxt       = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata ({mem_rdata, r_mem_addr}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  // FSM state, bus request and fetch pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_fetch_addr <= ADDR_W'(RESET_VECTOR);
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_req_nxt;
      r_mem_addr   <= w_maddr_nxt;
      r_fetch_addr <= w_faddr_nxt;
    end
  end

  // Next-state logic: issue when space is free, redirect flushes, drain stale data.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_maddr_nxt = r_mem_addr;
    w_faddr_nxt = r_fetch_addr;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_flush     = 1'b1;
          w_faddr_nxt = redirect_addr;
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_maddr_nxt = redirect_addr;
        end else if (w_cnt_after_pop < CNT_W'(DEPTH)) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
          w_maddr_nxt = r_fetch_addr;
        end
      end
      REQ: begin
        if (redirect) begin
          w_flush     = 1'b1;
          w_faddr_nxt = redirect_addr;
          if (mem_ack) begin
            w_maddr_nxt = redirect_addr;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else if (mem_ack) begin
          w_faddr_nxt = w_faddr_inc;
          if (w_cnt_nxt < CNT_W'(DEPTH)) begin
            w_maddr_nxt = w_faddr_inc;
          end else begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (redirect) begin
          w_flush     = 1'b1;
          w_faddr_nxt = redirect_addr;
        end
        if (mem_ack) begin
          w_state_nxt = REQ;
          w_maddr_nxt = redirect ? redirect_addr : r_fetch_addr;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign q_count  = w_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, pop/refill, redirect cases,
// address wrap, reset mid-request and the optional bypass path.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        q_valid;
  logic [7:0]  q_data;
  logic [15:0] q_addr;
  logic        q_ready;
  logic [2:0]  q_count;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_queue #(.DEPTH(4), .ADDR_W(16), .DATA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .q_valid       (q_valid),
    .q_data        (q_data),
    .q_addr        (q_addr),
    .q_ready       (q_ready),
    .q_count       (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ack(input logic [7:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    step();
    mem_ack   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0; q_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",  32'(mem_req),  32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_q_valid",  32'(q_valid),  32'd0);
    chk("rst_q_count",  32'(q_count),  32'd0);

    // Fill: requests 0000..0003 acked back to back, decoder stalled.
    reset = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("fill_req",  32'(mem_req),  32'd1);
      chk("fill_addr", 32'(mem_addr), 32'(k));
      ack(8'(16 + k));
      chk("fill_count", 32'(q_count), 32'(k + 1));
    end
    chk("full_req_low", 32'(mem_req), 32'd0);
    chk("full_q_valid", 32'(q_valid), 32'd1);
    chk("full_q_addr",  32'(q_addr),  32'h0000);
    chk("full_q_data",  32'(q_data),  32'h10);

    // One pop frees one slot: exactly one new request at 0004.
    q_ready = 1'b1;
    step();
    q_ready = 1'b0;
    chk("pop_count",   32'(q_count),  32'd3);
    chk("pop_req",     32'(mem_req),  32'd1);
    chk("pop_addr",    32'(mem_addr), 32'h0004);
    chk("pop_q_addr",  32'(q_addr),   32'h0001);
    chk("pop_q_data",  32'(q_data),   32'h11);
    ack(8'h14);
    chk("refill_count", 32'(q_count), 32'd4);
    chk("refill_req",   32'(mem_req), 32'd0);
    step();
    chk("idle_req", 32'(mem_req), 32'd0);

    // Redirect in IDLE together with a pop: redirect wins, queue empties.
    q_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h2000;
    step();
    q_ready = 1'b0; redirect = 1'b0;
    chk("idle_redir_count", 32'(q_count),  32'd0);
    chk("idle_redir_valid", 32'(q_valid),  32'd0);
    chk("idle_redir_req",   32'(mem_req),  32'd1);
    chk("idle_redir_addr",  32'(mem_addr), 32'h2000);
    ack(8'h55);
    ack(8'h56);
    chk("t2000_count", 32'(q_count), 32'd2);

    // Reset mid-request clears immediately; a late ack after release is ignored.
    reset = 1'b1;
    #1;
    chk("async_rst_req",   32'(mem_req), 32'd0);
    chk("async_rst_count", 32'(q_count), 32'd0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hBB;
    step();
    mem_ack = 1'b0;
    chk("late_ack_count", 32'(q_count),  32'd0);
    chk("late_ack_req",   32'(mem_req),  32'd1);
    chk("late_ack_addr",  32'(mem_addr), 32'h0000);

    // Redirect to 1234 while the request to 0002 is pending, ack 3 cycles later.
    ack(8'hA0);
    ack(8'hA1);
    chk("pend_addr", 32'(mem_addr), 32'h0002);
    redirect = 1'b1; redirect_addr = 16'h1234;
    step();
    redirect = 1'b0;
    chk("drain_count", 32'(q_count),  32'd0);
    chk("drain_valid", 32'(q_valid),  32'd0);
    chk("drain_req",   32'(mem_req),  32'd1);
    chk("drain_addr",  32'(mem_addr), 32'h0002);
    step();
    step();
    ack(8'hEE);
    chk("drop_count", 32'(q_count),  32'd0);
    chk("drop_valid", 32'(q_valid),  32'd0);
    chk("drop_req",   32'(mem_req),  32'd1);
    chk("drop_addr",  32'(mem_addr), 32'h1234);
    ack(8'h3A);
    chk("tgt_q_valid", 32'(q_valid),  32'd1);
    chk("tgt_q_addr",  32'(q_addr),   32'h1234);
    chk("tgt_q_data",  32'(q_data),   32'h3A);
    chk("tgt_next",    32'(mem_addr), 32'h1235);

    // Redirect to 0800 in the same cycle as an ack.
    redirect = 1'b1; redirect_addr = 16'h0800;
    ack(8'h99);
    redirect = 1'b0;
    chk("ra_req",   32'(mem_req),  32'd1);
    chk("ra_addr",  32'(mem_addr), 32'h0800);
    chk("ra_valid", 32'(q_valid),  32'd0);
    chk("ra_count", 32'(q_count),  32'd0);

    // Two redirects while draining: the later target wins; then wrap FFFF->0000.
    redirect = 1'b1; redirect_addr = 16'h1111;
    step();
    redirect_addr = 16'hFFFF;
    step();
    redirect = 1'b0;
    chk("dd_addr_held", 32'(mem_addr), 32'h0800);
    ack(8'h00);
    chk("latest_wins", 32'(mem_addr), 32'hFFFF);
    ack(8'h77);
    chk("wrap_addr",   32'(mem_addr), 32'h0000);
    chk("wrap_q_addr", 32'(q_addr),   32'hFFFF);
    chk("wrap_q_data", 32'(q_data),   32'h77);
    chk("wrap_count",  32'(q_count),  32'd1);

    // Drain the queue, then keep popping while empty.
    q_ready = 1'b1;
    step();
    chk("popout_count", 32'(q_count), 32'd0);
    step();
    chk("empty_pop_count", 32'(q_count), 32'd0);
    chk("empty_pop_valid", 32'(q_valid), 32'd0);

    // Empty queue, decoder ready, ack with 3E.
    mem_ack = 1'b1; mem_rdata = 8'h3E;
`ifdef FETCH_BYPASS_EN
    #1;
    chk("byp_valid", 32'(q_valid), 32'd1);
    chk("byp_data",  32'(q_data),  32'h3E);
    chk("byp_addr",  32'(q_addr),  32'h0000);
    step();
    mem_ack = 1'b0;
    chk("byp_count", 32'(q_count), 32'd0);
`else
    #1;
    chk("nobyp_valid", 32'(q_valid), 32'd0);
    step();
    mem_ack = 1'b0; q_ready = 1'b0;
    chk("nobyp_count", 32'(q_count), 32'd1);
    chk("nobyp_data",  32'(q_data),  32'h3E);
    chk("nobyp_addr",  32'(q_addr),  32'h0000);
`endif
    chk("after_3e_addr", 32'(mem_addr), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch stage for the 8085 core; sits directly downstream of the program-counter stage.
- Issues byte reads to program memory over a req/ack handshake and buffers returned opcode/operand bytes, each tagged with its address, in a small FIFO for the decoder.
- On a branch redirect (same control/branch_addr pair that drives the PC), flushes the FIFO and restarts fetching at the branch target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 16, fetch address width.
- DATA_W, 8, instruction byte width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- redirect  input  1  branch taken this cycle; flush and reload fetch address.
- redirect_addr  input  ADDR_W  branch target address.
- mem_req  output  1  memory read request, registered.
- mem_addr  output  ADDR_W  read address, registered, stable while mem_req is high.
- mem_ack  input  1  single-cycle pulse; the read completes in that cycle.
- mem_rdata  input  DATA_W  read data, valid when mem_ack is high.
- q_valid  output  1  head entry valid.
- q_data  output  DATA_W  head instruction byte.
- q_addr  output  ADDR_W  address of the head byte.
- q_ready  input  1  decoder pops the head when q_valid and q_ready are both high.
- q_count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async): mem_req=0, mem_addr=0, q_valid=0, q_count=0, fetch_addr=16'h0000, state=IDLE.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding; response will be kept.
  - DRAIN: request outstanding; response will be discarded.
- At most one request is outstanding at any time.
- IDLE->REQ: when q_count + 0 < DEPTH after this cycle's pop, and no redirect this cycle.
  - On entry, mem_req=1 and mem_addr=fetch_addr in the next cycle.
  - Space is reserved at issue, so a push can never overflow the FIFO.
- REQ, mem_ack=1:
  - Push {mem_rdata, mem_addr}; fetch_addr++ (wraps FFFF->0000).
  - If space remains, stay in REQ with a back-to-back request at the new address; otherwise go to IDLE (mem_req=0).
- Throughput: one byte per ack, ack-to-next-request 0 dead cycles; push visible on q_valid 1 cycle after mem_ack.
- REQ + redirect, no ack: flush FIFO, fetch_addr=redirect_addr, go to DRAIN.
  - mem_req stays high with the old address; a request is never withdrawn.
- REQ + redirect + ack in the same cycle: discard the data, flush, fetch_addr=redirect_addr, go to REQ at redirect_addr next cycle.
- DRAIN + mem_ack: drop the data, go to REQ at fetch_addr next cycle.
- DRAIN + redirect: update fetch_addr and stay in DRAIN; the latest redirect wins.
- IDLE + redirect: flush, load fetch_addr, issue the request next cycle.
- Redirect and pop in the same cycle: redirect wins; the pop is ignored and the FIFO is empty next cycle.
- Push and pop in the same cycle: q_count unchanged; allowed when full (push reserved).
- Pop when empty: ignored.
- Reset mid-request: all state is cleared immediately; a late mem_ack arriving in IDLE is ignored.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state is REQ, mem_ack=1 and no redirect, q_valid/q_data/q_addr are driven combinationally from mem_rdata/mem_addr in the same cycle.
  - If q_ready is also high, the byte is consumed without being written to the FIFO.
- Undefined: all outputs come from the FIFO; 1-cycle ack-to-q_valid latency.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, DRAIN)
  - ADDR_W and DATA_W defaults
  - RESET_VECTOR = 16'h0000
- Sub-module fetch_fifo: synchronous FIFO of width ADDR_W+DATA_W, depth DEPTH, with push/pop/flush and count. The FSM and fetch_addr stay in fetch_queue.

Test Plan:
- Release reset with mem_ack always returning the next cycle and q_ready=0 -> requests to 0000..0003, then mem_req drops; q_count=4; q_addr=0000.
- Queue full, then pop once -> exactly one new request at 0004; q_count returns to 4.
- Redirect to 1234 while a request to 0002 is pending, ack 3 cycles later -> FIFO empty, old data dropped, next mem_addr=1234.
- Redirect to 0800 in the same cycle as mem_ack -> data discarded, mem_req at 0800 next cycle, q_valid=0.
- Fetch address FFFF acked -> next mem_addr=0000; q_addr of that byte=FFFF.
- With FETCH_BYPASS_EN, empty queue, q_ready=1, ack with rdata=3E -> q_valid=1 and q_data=3E in the ack cycle; q_count stays 0.
